// File: rtl/draw_image_blit.sv
// Image blitter: streams an IMG_W x IMG_H image from a synchronous colour ROM to the
// VGA pixel write port at a latched origin, with clipping, colour key and horizontal flip.
module draw_image_blit #(
    parameter int IMG_W         = 160,
    parameter int IMG_H         = 120,
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int COLOUR_W      = 9,
    parameter int ADDR_W        = 15,
    parameter int TRANSP_EN     = 0,
    parameter int TRANSP_COLOUR = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x_origin,
    input  logic [Y_W-1:0]      y_origin,
    input  logic                hflip,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_last;
    logic                r_drain_cnt;
    logic                r_busy;
    logic                r_done;

    logic [ADDR_W-1:0]   r_addr;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [X_W-1:0]      r_x_org;
    logic [Y_W-1:0]      r_y_org;
    logic                r_hflip;

    logic                r_v2;
    logic [CW-1:0]       r_col2;
    logic [RW-1:0]       r_row2;

    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;

    logic [CW-1:0]       w_ec;
    logic [X_W:0]        w_sx;
    logic [Y_W:0]        w_sy;
    logic                w_key_hit;
    logic                w_visible;

    assign w_last = (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1));

    // Next-state decode and start acceptance
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_FETCH;
                    w_accept = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (w_last) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
        end
    end

    // Pixel index generator; address and (col,row) advance together so no multiply is needed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_x_org <= '0;
            r_y_org <= '0;
            r_hflip <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_x_org <= x_origin;
            r_y_org <= y_origin;
            r_hflip <= hflip;
        end else if ((r_state == S_FETCH) && !w_last) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end else begin
            r_addr <= r_addr;
        end
    end

    // Tags aligned with rom_q, which arrives one cycle after the address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v2   <= 1'b0;
            r_col2 <= '0;
            r_row2 <= '0;
        end else begin
            r_v2   <= (r_state == S_FETCH);
            r_col2 <= r_col;
            r_row2 <= r_row;
        end
    end

    assign w_ec      = r_hflip ? (CW'(IMG_W - 1) - r_col2) : r_col2;
    assign w_sx      = {1'b0, r_x_org} + (X_W + 1)'(w_ec);
    assign w_sy      = {1'b0, r_y_org} + (Y_W + 1)'(r_row2);
    assign w_key_hit = (TRANSP_EN != 0) && (rom_q == COLOUR_W'(TRANSP_COLOUR));
    assign w_visible = (32'(w_sx) < 32'(SCREEN_W)) && (32'(w_sy) < 32'(SCREEN_H)) && !w_key_hit;

    // Output stage: coordinates always update for a valid pixel, plot only if on-screen and opaque
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else if (r_v2) begin
            r_x      <= w_sx[X_W-1:0];
            r_y      <= w_sy[Y_W-1:0];
            r_colour <= rom_q;
            r_plot   <= w_visible;
        end else begin
            r_plot   <= 1'b0;
        end
    end

    assign rom_address = r_addr;
    assign x           = r_x;
    assign y           = r_y;
    assign colour      = r_colour;
    assign plot        = r_plot;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_draw_image_blit.sv
// Randomised bench for draw_image_blit (20x20 image, colour key 9'h1FF) against a
// per-cycle behavioural model derived from the pixel-timing rules.
module tb_draw_image_blit;

    localparam int IW = 20;
    localparam int IH = 20;
    localparam int N  = IW * IH;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  x_origin;
    logic [6:0]  y_origin;
    logic        hflip;
    logic [14:0] rom_address;
    logic [8:0]  rom_q;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    draw_image_blit #(
        .IMG_W(IW), .IMG_H(IH), .TRANSP_EN(1), .TRANSP_COLOUR('h1FF)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_origin(x_origin), .y_origin(y_origin), .hflip(hflip),
        .rom_address(rom_address), .rom_q(rom_q),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [0:N-1];
    always @(posedge clk) rom_q <= (rom_address < 15'(N)) ? rom[rom_address] : 9'd0;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0, m_S = 0, m_acc = 0, rel;
    bit m_act = 0, m_idle = 1;
    int m_xo, m_yo;
    bit m_hf;
    logic [7:0] ex = '0;
    logic [6:0] ey = '0;
    logic [8:0] ecl = '0;
    bit eb, ed, ep;
    int k, col, row, ec, sx, sy;

    int d_x [0:409];
    int d_y [0:409];
    int d_c [0:409];
    int dut_plots = 0, dut_total = 0, dut_dones = 0, done_cyc = 0, prev_done_cyc = 0;
    int lp_x = 0, lp_y = 0, lp_c = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle model: what each output must be, derived from the start cycle and pixel index
    always @(negedge clk) begin
        if (!resetn) begin
            m_act = 0; m_idle = 1;
            ex = '0; ey = '0; ecl = '0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_plot", plot, 0);
            chk("rst_addr", rom_address, 0);
            chk("rst_x", x, 0);
            chk("rst_y", y, 0);
            chk("rst_colour", colour, 0);
        end else begin
            rel = cyc - m_S;
            eb = m_act && rel >= 1 && rel <= N + 3;
            ed = m_act && rel == N + 3;
            ep = 0;
            if (m_act && rel >= 3 && rel <= N + 2) begin
                k   = rel - 3;
                col = k % IW;
                row = k / IW;
                ec  = m_hf ? IW - 1 - col : col;
                sx  = m_xo + ec;
                sy  = m_yo + row;
                ex  = 8'(sx);
                ey  = 7'(sy);
                ecl = rom[k];
                ep  = (sx < 160) && (sy < 120) && (rom[k] != 9'h1FF);
            end
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("plot", plot, ep);
            chk("x", x, ex);
            chk("y", y, ey);
            chk("colour", colour, ecl);
            if (m_act && rel >= 1 && rel <= N) chk("rom_address", rom_address, rel - 1);
            if (m_act && rel >= 0 && rel < 410) begin
                d_x[rel] = x; d_y[rel] = y; d_c[rel] = colour;
            end
            if (plot) begin
                dut_plots++; dut_total++;
                lp_x = x; lp_y = y; lp_c = colour;
            end
            if (done) begin
                dut_dones++; prev_done_cyc = done_cyc; done_cyc = cyc;
            end
            if (!eb && start) begin
                m_act = 1; m_S = cyc; m_acc++;
                m_xo = x_origin; m_yo = y_origin; m_hf = hflip;
                dut_plots = 0;
            end
            m_idle = !(m_act && (cyc - m_S) <= N + 3);
        end
        cyc++;
    end

    task automatic wait_accept(input int prev_acc, input int n);
        int t = 0;
        while (m_acc < prev_acc + n && t < 2000) begin @(posedge clk); t++; end
        if (m_acc < prev_acc + n) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: accepted %0d, required %0d", m_acc - prev_acc, n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!m_idle && t < 2000) begin @(posedge clk); t++; end
        if (!m_idle) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: still busy, required idle");
        end
    endtask

    task automatic run_blit(input int xo, input int yo, input bit hf);
        int a;
        a = m_acc;
        @(posedge clk); #1;
        x_origin = 8'(xo); y_origin = 7'(yo); hflip = hf; start = 1'b1;
        wait_accept(a, 1);
        #1;
        start = 1'b0;
        x_origin = 8'($urandom); y_origin = 7'($urandom); hflip = 1'($urandom);
        wait_idle();
    endtask

    task automatic fill_rom(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 0)      rom[i] = 9'(i);
            else if (mode == 1) rom[i] = 9'h1FF;
            else                rom[i] = ($urandom_range(3) == 0) ? 9'h1FF : 9'($urandom);
        end
    endtask

    initial begin
        int d0, t0, a;
        resetn = 1'b0; start = 1'b0; x_origin = '0; y_origin = '0; hflip = 1'b0;
        fill_rom(0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // mirrored blit at origin: literal pins on the model
        run_blit(0, 0, 1'b1);
        chk("hf_first_x", d_x[3], 19);
        chk("hf_first_y", d_y[3], 0);
        chk("hf_first_c", d_c[3], 0);
        chk("hf_row0_end_x", d_x[22], 0);
        chk("hf_row0_end_c", d_c[22], 19);
        chk("hf_row1_x", d_x[23], 19);
        chk("hf_row1_y", d_y[23], 1);
        chk("hf_row1_c", d_c[23], 20);
        chk("hf_plots", dut_plots, 400);
        chk("hf_done_lat", done_cyc - m_S, 403);

        // bottom-right clipping
        d0 = dut_dones;
        run_blit(150, 110, 1'b0);
        chk("clip_plots", dut_plots, 100);
        chk("clip_dones", dut_dones - d0, 1);
        chk("clip_done_lat", done_cyc - m_S, 403);

        // colour key: only index 21 is opaque
        fill_rom(1);
        rom[21] = 9'h0AA;
        run_blit(10, 10, 1'b0);
        chk("key_plots", dut_plots, 1);
        chk("key_x", lp_x, 11);
        chk("key_y", lp_y, 11);
        chk("key_c", lp_c, 'h0AA);

        repeat (6) begin
            fill_rom(2);
            run_blit(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), 1'($urandom));
        end

        // start held high across two blits
        fill_rom(0);
        d0 = dut_dones;
        a  = m_acc;
        @(posedge clk); #1;
        x_origin = 8'd5; y_origin = 7'd5; hflip = 1'b0; start = 1'b1;
        wait_accept(a, 2);
        #1 start = 1'b0;
        wait_idle();
        chk("held_dones", dut_dones - d0, 2);
        chk("held_spacing", done_cyc - prev_done_cyc, 404);

        // asynchronous reset while pixel 200 is being fetched
        fill_rom(2);
        a = m_acc;
        @(posedge clk); #1;
        x_origin = 8'd20; y_origin = 7'd30; hflip = 1'b0; start = 1'b1;
        wait_accept(a, 1);
        #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("async_plot", plot, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_addr", rom_address, 0);
        @(posedge clk); #1 resetn = 1'b1;
        t0 = dut_total;
        repeat (50) @(posedge clk);
        chk("post_rst_plots", dut_total - t0, 0);
        run_blit(3, 4, 1'b1);
        chk("post_rst_done_lat", done_cyc - m_S, 403);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/draw_image_blit.md
Name: draw_image_blit

Overview:
- Parametrised image blitter: streams an IMG_W x IMG_H image from an external synchronous colour ROM to the VGA adapter's pixel write port, at a run-time origin.
- Generalises the full-screen background drawers:
  - any image size and screen size;
  - start/busy/done handshake;
  - on-screen clipping;
  - optional transparent colour key;
  - horizontal-flip mode.
- Sits between the game control FSM (issues start, waits for done) and the VGA adapter (x, y, colour, plot).

Parameters:
- IMG_W, 160, image width in pixels (>=1)
- IMG_H, 120, image height in pixels (>=1)
- SCREEN_W, 160, visible screen width; pixels at x >= SCREEN_W are clipped
- SCREEN_H, 120, visible screen height; pixels at y >= SCREEN_H are clipped
- X_W, 8, width of x origin and x output
- Y_W, 7, width of y origin and y output
- COLOUR_W, 9, colour width
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- TRANSP_EN, 0, 1 enables the colour key
- TRANSP_COLOUR, 0, key value; pixels equal to it are not plotted when TRANSP_EN=1

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request a blit; sampled only while busy=0
- x_origin  in  X_W  screen x of image column 0 (top-left corner); latched on accepted start
- y_origin  in  Y_W  screen y of image row 0; latched on accepted start
- hflip  in  1  1 = mirror the image horizontally; latched on accepted start
- rom_address  out  ADDR_W  pixel index into the image ROM, registered
- rom_q  in  COLOUR_W  ROM data; valid one cycle after rom_address is registered by the ROM
- x  out  X_W  pixel x for the VGA adapter
- y  out  Y_W  pixel y for the VGA adapter
- colour  out  COLOUR_W  pixel colour for the VGA adapter
- plot  out  1  VGA write enable for the current x/y/colour
- busy  out  1  blit in progress
- done  out  1  one-cycle pulse when the blit completes

Behaviour:
- Reset (asynchronous, any time, including mid-blit):
  - rom_address, x, y, colour, plot, busy, done, all counters and pipeline registers clear to 0.
  - State returns to IDLE; no further plots until a new start.
- States:
  - IDLE: busy=0. start=1 in cycle S latches the origin and hflip, clears col/row, sets rom_address=0, then moves to FETCH.
  - FETCH: busy=1. One pixel index issued per cycle:
    - col advances 0..IMG_W-1, then wraps to 0 while row increments.
    - rom_address increments by 1; no multiplier is used.
    - After index N-1 (N=IMG_W*IMG_H) is issued, moves to DRAIN.
  - DRAIN: busy=1. Two cycles to flush the pipeline, then DONE.
  - DONE: busy=1, done=1 for exactly one cycle, plot=0. Returns to IDLE.
- Timing for pixel index k = row*IMG_W + col:
  - rom_address=k in cycle S+1+k.
  - x/y/colour/plot for that pixel are valid in cycle S+3+k (2-cycle pipeline).
  - (col, row) tags travel alongside the ROM read.
  - Last pixel is valid in cycle S+2+N; done in S+3+N; busy=0 again in S+4+N.
- Coordinates:
  - Effective column ec = hflip ? IMG_W-1-col : col.
  - sx = x_origin + ec, computed at X_W+1 bits (no wrap).
  - sy = y_origin + row, computed at Y_W+1 bits.
  - x and y outputs are the low X_W / Y_W bits.
- plot=1 only when all of the following hold:
  - the output stage holds a valid pixel;
  - sx < SCREEN_W;
  - sy < SCREEN_H;
  - not (TRANSP_EN and rom_q == TRANSP_COLOUR).
- Clipped or transparent pixels still occupy their cycle: x/y/colour update, plot=0, timing unchanged.
- Outside valid pixel cycles, plot=0; x/y/colour hold their last values.
- start while busy=1, including the DONE cycle, is ignored. Origin and hflip changes mid-blit have no effect.
- IMG_W=1 and/or IMG_H=1 are legal; N=1 gives done in S+4.

Test Plan:
- Default params, origin (0,0), hflip=0, ROM[k]=k[8:0]:
  - 19200 plots;
  - first output x=0, y=0, colour=0 in S+3;
  - last output x=159, y=119, colour=19199 mod 512 in S+19202;
  - done pulse only in S+19203;
  - busy high S+1..S+19203.
- IMG_W=IMG_H=20, origin (150,110):
  - 400 output cycles, exactly 100 plots (col<10, row<10);
  - no plot with x>=160 or y>=120;
  - done in S+403.
- IMG_W=IMG_H=20, TRANSP_EN=1, TRANSP_COLOUR=9'h1FF, ROM all 9'h1FF except index 21 = 9'h0AA, origin (10,10):
  - single plot at x=11, y=11, colour 9'h0AA.
- IMG_W=4, IMG_H=2, hflip=1, origin (0,0), ROM[k]=k:
  - row 0 emits x=3,2,1,0 with colours 0,1,2,3;
  - row 1 emits y=1, same x order, colours 4..7.
- start held high continuously, IMG_W=IMG_H=20:
  - second blit begins only after busy falls; exactly one done per blit, spaced 404 cycles.
- resetn pulsed low for 1 cycle mid-blit at k=200:
  - plot, busy, done, rom_address read 0 immediately (asynchronous);
  - no further plots;
  - a new start after release gives full, correct timing.
